fr_adder_prefix: RTL and testbench
==================================

Name: fr_adder_prefix

Overview:
- Pipelined Kogge-Stone carry-prefix and sum stage of the floating-point MAC mantissa adder.
- Sits directly downstream of the G/P prepare stage and consumes its registered outputs:
  - generate vector G0 and propagate vector P0, each WIDTH bits, where bit 0 is the carry-in slot;
  - the pass-through result sign.
- Produces the (WIDTH-1)-bit mantissa sum plus carry-out, with the sign aligned to the sum.

Parameters:
- WIDTH, 25, width of G0/P0 including the bit-0 carry-in slot. Mantissa width is WIDTH-1.
- LEVELS, localparam = ceil(log2(WIDTH)) (5 at default), number of prefix levels. Not overridable.

Ports:
- clock  input  1  rising-edge clock for all registers.
- resetn  input  1  synchronous active-low reset, sampled on the rising edge of clock.
- enable  input  1  pipeline advance. 1 = all stages shift; 0 = every register holds.
- in_valid  input  1  G0/P0/in_out_sign carry a valid operand this cycle.
- G0  input  WIDTH  generate vector from the prepare stage.
- P0  input  WIDTH  propagate vector from the prepare stage.
- in_out_sign  input  1  result sign, carried unchanged.
- out_valid  output  1  out_sum/out_out_sign valid.
- out_sum  output  WIDTH  {carry_out, sum[WIDTH-2:0]}.
- out_out_sign  output  1  sign aligned with out_sum.

Behaviour:
- Reset: resetn=0 at a rising edge clears all stage registers, including every valid bit, to 0. Outputs reset to out_valid=0, out_sum=0, out_out_sign=0.
  - Reset takes priority over enable.
  - Reset mid-operation discards every in-flight operand. No output may pulse valid afterwards until new in_valid data has traversed the full pipeline.
- Each level stage k (k=1..LEVELS) registers:
  - group generate Gk and group propagate Pk;
  - the original P0 (delayed copy);
  - the sign and the valid bit.
- Level k recurrence, span d = 2^(k-1):
  - for i >= d: Gk[i] = G(k-1)[i] | (P(k-1)[i] & G(k-1)[i-d]); Pk[i] = P(k-1)[i] & P(k-1)[i-d];
  - for i < d: Gk[i] = G(k-1)[i]; Pk[i] = P(k-1)[i].
  - Level 0 is the G0/P0 inputs.
- After level LEVELS, GL[i] is the carry out of bit i.
- Sum stage, registered (one more register):
  - sum[j] = P0[j+1] ^ GL[j] for j = 0..WIDTH-2;
  - carry_out = GL[WIDTH-1];
  - out_sum = {carry_out, sum}.
- Latency: LEVELS+1 clock edges with enable=1 (6 at default). Throughput is one operand per cycle.
- enable=0:
  - all data, sign and valid registers hold their values, and outputs are stable;
  - inputs presented that cycle are not captured. The upstream stage must hold them.
- in_valid=0 with enable=1: a bubble enters. Data registers still load, but out_valid is 0 when that slot reaches the output. Data under out_valid=0 is don't-care.
- Arithmetic is unsigned with no saturation. carry_out=1 signals mantissa overflow for the downstream normaliser.
- Bit 0 of G0 acts as carry-in; bit 0 of P0 is ignored in the sum.

Optional Feature:
- Macro: FR_PREFIX_CIN_EN.
- Defined:
  - adds input port cin (1 bit), sampled with G0;
  - level-0 G[0] = cin and P[0] = 0, so the incoming G0[0] and P0[0] are ignored;
  - cin propagates with the same latency. This enables round-up increment in the same add.
- Undefined:
  - no cin port;
  - level-0 G[0] = G0[0] and P[0] = P0[0] as supplied (0 from the prepare stage).

Test Plan:
- Full-width carry ripple: G0=25'h0000002, P0=25'h1FFFFFC (0xFFFFFF+0x000001), in_valid=1, enable=1 -> after 6 cycles out_valid=1, out_sum=25'h1000000.
- No-carry add with sign: G0=0, P0=25'h0C00000 (0x400000+0x200000), in_out_sign=1 -> out_sum=25'h0600000, out_out_sign=1.
- Back-to-back stream with a stall:
  - 8 consecutive operands, then enable=0 for 3 cycles mid-stream;
  - expect results in order, no drops or duplicates, outputs frozen during the stall, and total latency 6+3.
- Reset mid-flight: resetn=0 for one edge while 4 operands are in flight -> out_valid=0 on every following cycle until a new operand arrives and completes 6 cycles later; out_sum=0 right after reset.
- Bubbles and overflow:
  - in_valid pattern 1,0,1 -> out_valid pattern 1,0,1 at the output;
  - G0=25'h1000000, P0=0 (0x800000+0x800000) -> out_sum=25'h1000000.
- FR_PREFIX_CIN_EN defined: G0=0, P0=25'h1FFFFFE, cin=1 -> out_sum=25'h1000000.
- FR_PREFIX_CIN_EN undefined, same G0/P0 -> out_sum=25'h0FFFFFF.

Source files
------------

// File: rtl/fr_adder_prefix.sv
// fr_adder_prefix: pipelined Kogge-Stone carry-prefix and sum stage of the
// FP MAC mantissa adder. Consumes registered G0/P0 from the prepare stage,
// where bit 0 is the carry-in slot. It produces {carry_out, sum} with the
// result sign aligned to it.
// Latency is LEVELS+1 enabled clock edges, with one operand per cycle.
// Optional macro FR_PREFIX_CIN_EN adds a cin port. It replaces the bit-0
// slot, giving G[0]=cin and P[0]=0, so a round-up increment fits in the same add.

module fr_adder_prefix #(
  parameter int WIDTH = 25
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             enable,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] G0,
  input  logic [WIDTH-1:0] P0,
  input  logic             in_out_sign,
`ifdef FR_PREFIX_CIN_EN
  input  logic             cin,
`endif
  output logic             out_valid,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_out_sign
);

  localparam int LEVELS = $clog2(WIDTH);

  logic [WIDTH-1:0] g_l0;
  logic [WIDTH-1:0] p_l0;

  // Per-level registers. Index k holds prefix level k+1.
  logic [WIDTH-1:0] g_q   [LEVELS];
  logic [WIDTH-1:0] p_q   [LEVELS];
  logic [WIDTH-2:0] p0_q  [LEVELS];
  logic [LEVELS-1:0] sign_q;
  logic [LEVELS-1:0] valid_q;

  logic [WIDTH-1:0] g_src [LEVELS];
  logic [WIDTH-1:0] p_src [LEVELS];
  logic [WIDTH-1:0] g_nxt [LEVELS];
  logic [WIDTH-1:0] p_nxt [LEVELS];

  logic [WIDTH-2:0] sum_nxt;
  logic             cout_nxt;

`ifdef FR_PREFIX_CIN_EN
  // cin takes over the bit-0 slot. The incoming slot bits are superseded.
  logic unused_slot;
  assign g_l0        = {G0[WIDTH-1:1], cin};
  assign p_l0        = {P0[WIDTH-1:1], 1'b0};
  assign unused_slot = ^{G0[0], P0[0]};
`else
  assign g_l0 = G0;
  assign p_l0 = P0;
`endif

  // Select the operand feeding each prefix level: inputs for level 1, previous register after.
  always_comb begin
    g_src[0] = g_l0;
    p_src[0] = p_l0;
    for (int k = 1; k < LEVELS; k++) begin
      g_src[k] = g_q[k-1];
      p_src[k] = p_q[k-1];
    end
  end

  // Kogge-Stone combine with span 2^k. Bits below the span pass straight through
  // (the shifted-in zeros leave G unchanged, and the low mask keeps P).
  always_comb begin
    for (int k = 0; k < LEVELS; k++) begin
      g_nxt[k] = g_src[k] | (p_src[k] & (g_src[k] << (1 << k)));
      p_nxt[k] = p_src[k] & ((p_src[k] << (1 << k)) | ~({WIDTH{1'b1}} << (1 << k)));
    end
  end

  // After the last level, g_q holds the carry out of every bit position.
  assign sum_nxt  = p0_q[LEVELS-1] ^ g_q[LEVELS-1][WIDTH-2:0];
  assign cout_nxt = g_q[LEVELS-1][WIDTH-1];

  // Pipeline advance: reset clears everything and overrides enable; enable=0 freezes all stages.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      for (int k = 0; k < LEVELS; k++) begin
        g_q[k]  <= '0;
        p_q[k]  <= '0;
        p0_q[k] <= '0;
      end
      sign_q       <= '0;
      valid_q      <= '0;
      out_valid    <= 1'b0;
      out_sum      <= '0;
      out_out_sign <= 1'b0;
    end else if (enable) begin
      for (int k = 0; k < LEVELS; k++) begin
        g_q[k] <= g_nxt[k];
        p_q[k] <= p_nxt[k];
      end
      p0_q[0]    <= p_l0[WIDTH-1:1];
      sign_q[0]  <= in_out_sign;
      valid_q[0] <= in_valid;
      for (int k = 1; k < LEVELS; k++) begin
        p0_q[k]    <= p0_q[k-1];
        sign_q[k]  <= sign_q[k-1];
        valid_q[k] <= valid_q[k-1];
      end
      out_valid    <= valid_q[LEVELS-1];
      out_sum      <= {cout_nxt, sum_nxt};
      out_out_sign <= sign_q[LEVELS-1];
    end
  end

endmodule

// File: tb/tb_fr_adder_prefix.sv
// Bench for fr_adder_prefix: a table of hand-computed vectors is streamed
// back-to-back, then separate sequences cover stall, reset, bubbles and carry-in.

module tb_fr_adder_prefix;

  localparam int WIDTH = 25;
  localparam int NVEC  = 8;

  logic             clock = 1'b0;
  logic             resetn;
  logic             enable;
  logic             in_valid;
  logic [WIDTH-1:0] G0;
  logic [WIDTH-1:0] P0;
  logic             in_out_sign;
`ifdef FR_PREFIX_CIN_EN
  logic             cin;
`endif
  logic             out_valid;
  logic [WIDTH-1:0] out_sum;
  logic             out_out_sign;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic             sign;
    logic [WIDTH-1:0] exp_sum;
    logic             exp_sign;
  } vec_t;

  vec_t tbl [NVEC];

  fr_adder_prefix #(.WIDTH(WIDTH)) dut (
    .clock        (clock),
    .resetn       (resetn),
    .enable       (enable),
    .in_valid     (in_valid),
    .G0           (G0),
    .P0           (P0),
    .in_out_sign  (in_out_sign),
`ifdef FR_PREFIX_CIN_EN
    .cin          (cin),
`endif
    .out_valid    (out_valid),
    .out_sum      (out_sum),
    .out_out_sign (out_out_sign)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int idx, input logic v);
    G0          = tbl[idx].g;
    P0          = tbl[idx].p;
    in_out_sign = tbl[idx].sign;
    in_valid    = v;
  endtask

  task automatic flush;
    in_valid = 1'b0;
    enable   = 1'b1;
    repeat (7) tick();
  endtask

  // One operand through an empty pipe: absent at edge 5, present at edge 6.
  task automatic run_single(input string name, input logic [WIDTH-1:0] g, input logic [WIDTH-1:0] p,
                            input logic s, input logic [WIDTH-1:0] es, input logic ess);
    flush();
    G0 = g; P0 = p; in_out_sign = s; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    check({name, "_early"}, 32'(out_valid), 32'(1'b0));
    tick();
    check({name, "_valid"}, 32'(out_valid), 32'(1'b1));
    check({name, "_sum"}, 32'(out_sum), 32'(es));
    check({name, "_sign"}, 32'(out_out_sign), 32'(ess));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int rx;
    int k;
    int ghost;
    int arrive [NVEC];

    tbl[0] = '{25'h0000002, 25'h1FFFFFC, 1'b0, 25'h1000000, 1'b0}; // FFFFFF + 000001
    tbl[1] = '{25'h0000000, 25'h0C00000, 1'b1, 25'h0600000, 1'b1}; // 400000 + 200000
    tbl[2] = '{25'h1000000, 25'h0000000, 1'b0, 25'h1000000, 1'b0}; // 800000 + 800000
    tbl[3] = '{25'h0000000, 25'h1FFFFFE, 1'b1, 25'h0FFFFFF, 1'b1}; // AAAAAA + 555555
    tbl[4] = '{25'h0000002, 25'h0000004, 1'b0, 25'h0000004, 1'b0}; // 000003 + 000001
    tbl[5] = '{25'h0000000, 25'h0EEEEEE, 1'b1, 25'h0777777, 1'b1}; // 123456 + 654321
    tbl[6] = '{25'h1FFFFFE, 25'h0000000, 1'b0, 25'h1FFFFFE, 1'b0}; // FFFFFF + FFFFFF
    tbl[7] = '{25'h01E1E1E, 25'h0000000, 1'b1, 25'h01E1E1E, 1'b1}; // 0F0F0F + 0F0F0F

    resetn = 1'b0; enable = 1'b1; in_valid = 1'b0;
    G0 = '0; P0 = '0; in_out_sign = 1'b0;
`ifdef FR_PREFIX_CIN_EN
    cin = 1'b0;
`endif
    repeat (2) tick();
    check("reset_valid", 32'(out_valid), 32'(1'b0));
    check("reset_sum", 32'(out_sum), 32'(0));
    check("reset_sign", 32'(out_out_sign), 32'(1'b0));
    resetn = 1'b1;

    // Back-to-back table stream: the vector driven in iteration c emerges after iteration c+5.
    for (int c = 0; c < NVEC + 5; c++) begin
      if (c < NVEC) drive(c, 1'b1);
      else in_valid = 1'b0;
      tick();
      if (c >= 5) begin
        check($sformatf("tbl%0d_valid", c - 5), 32'(out_valid), 32'(1'b1));
        check($sformatf("tbl%0d_sum", c - 5), 32'(out_sum), 32'(tbl[c-5].exp_sum));
        check($sformatf("tbl%0d_sign", c - 5), 32'(out_out_sign), 32'(tbl[c-5].exp_sign));
      end
    end

    // Stream with a 3-edge stall at edges 7..9, just after op0 reaches the output.
    flush();
    rx = 0;
    k  = 0;
    for (int i = 0; i < NVEC; i++) arrive[i] = -1;
    for (int c = 0; c < 24; c++) begin
      enable = !(c >= 6 && c <= 8);
      if (k < NVEC) drive(k, 1'b1);
      else in_valid = 1'b0;
      tick();
      if (!enable) begin
        check("stall_hold_valid", 32'(out_valid), 32'(1'b1));
        check("stall_hold_sum", 32'(out_sum), 32'(tbl[0].exp_sum));
      end else begin
        if (k < NVEC) k++;
        if (out_valid) begin
          if (rx < NVEC) begin
            check($sformatf("stream%0d_sum", rx), 32'(out_sum), 32'(tbl[rx].exp_sum));
            check($sformatf("stream%0d_sign", rx), 32'(out_out_sign), 32'(tbl[rx].exp_sign));
            arrive[rx] = c + 1;
          end
          rx++;
        end
      end
    end
    enable = 1'b1;
    check("stream_count", 32'(rx), 32'(NVEC));
    check("stream_lat_op0", 32'(arrive[0]), 32'(6));
    check("stream_lat_op2", 32'(arrive[2]), 32'(11));
    check("stream_lat_op7", 32'(arrive[7]), 32'(16));

    // Reset with four operands in flight, asserted while enable=0 to show reset wins.
    flush();
    for (int i = 0; i < 4; i++) begin
      drive(i, 1'b1);
      tick();
    end
    in_valid = 1'b0;
    resetn   = 1'b0;
    enable   = 1'b0;
    tick();
    resetn = 1'b1;
    enable = 1'b1;
    check("midrst_valid", 32'(out_valid), 32'(1'b0));
    check("midrst_sum", 32'(out_sum), 32'(0));
    check("midrst_sign", 32'(out_out_sign), 32'(1'b0));
    ghost = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid !== 1'b0) ghost++;
    end
    check("midrst_ghost_valid", 32'(ghost), 32'(0));
    drive(1, 1'b1);
    tick();
    in_valid = 1'b0;
    ghost = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (out_valid !== 1'b0) ghost++;
    end
    check("midrst_new_early", 32'(ghost), 32'(0));
    tick();
    check("midrst_new_valid", 32'(out_valid), 32'(1'b1));
    check("midrst_new_sum", 32'(out_sum), 32'(tbl[1].exp_sum));

    // Bubble pattern 1,0,1; the second operand overflows into carry_out.
    flush();
    drive(4, 1'b1); tick();
    drive(5, 1'b0); tick();
    drive(2, 1'b1); tick();
    in_valid = 1'b0;
    repeat (2) tick();
    tick();
    check("bubble_a_valid", 32'(out_valid), 32'(1'b1));
    check("bubble_a_sum", 32'(out_sum), 32'(25'h0000004));
    tick();
    check("bubble_gap_valid", 32'(out_valid), 32'(1'b0));
    tick();
    check("bubble_b_valid", 32'(out_valid), 32'(1'b1));
    check("bubble_b_sum", 32'(out_sum), 32'(25'h1000000));

`ifdef FR_PREFIX_CIN_EN
    cin = 1'b1;
    run_single("cin_round", 25'h0000000, 25'h1FFFFFE, 1'b1, 25'h1000000, 1'b1);
    cin = 1'b0;
    run_single("cin_slot_ignored", 25'h0000001, 25'h0000001, 1'b0, 25'h0000000, 1'b0);
`else
    run_single("no_cin", 25'h0000000, 25'h1FFFFFE, 1'b1, 25'h0FFFFFF, 1'b1);
    run_single("g0_slot_carry", 25'h0000001, 25'h0000000, 1'b0, 25'h0000001, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
